instr_fetch_queue: RTL and testbench

//  Upstream stage of the 8-bit compute unit. Captures 16-bit instructions from the
//  pad inputs on an asynchronous write strobe and queues them in a small FIFO.

---
 rtl/instr_fetch_queue_pkg.sv | 30 +++
 rtl/instr_fetch_queue_if.sv | 13 +
 rtl/instr_fetch_queue_strobe_sync_edge.sv | 26 ++
 rtl/instr_fetch_queue.sv | 76 +++++++
 tb/tb_instr_fetch_queue.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: opcodes, field slices, defaults.
// INSTR_NOP_DROP_EN (see instr_fetch_queue.sv) uses instr_is_droppable() from here.
`ifndef INSTR_FETCH_QUEUE_FIELDS
`define INSTR_FETCH_QUEUE_FIELDS
`define IFQ_OP(i)   i[15:12]
`define IFQ_TGT(i)  i[11:8]
`define IFQ_SRC0(i) i[7:4]
`define IFQ_SRC1(i) i[3:0]
`define IFQ_IMM(i)  i[7:0]
`endif

package instr_fetch_queue_pkg;

  localparam int IW_DEFAULT = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;

  // NOPs and the undefined upper half of the opcode space carry no work.
  function automatic logic instr_is_droppable(input logic [3:0] op);
    return (op == OP_NOP) || op[3];
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Issue-side handshake between the fetch queue and the compute unit.
interface instr_fetch_queue_if #(
  parameter int IW = instr_fetch_queue_pkg::IW_DEFAULT
);
  // valid/ready: a transfer happens on a clock edge where out_valid and out_ready
  // are both high; while out_valid=1 and out_ready=0 the master holds out_instr.
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic          out_ready;

  modport master (output out_valid, output out_instr, input out_ready);
  modport slave  (input out_valid, input out_instr, output out_ready);
endinterface

// File: rtl/instr_fetch_queue_strobe_sync_edge.sv
// Two-flop synchronizer for the pad write strobe plus a one-clock rising-edge pulse.
module instr_fetch_queue_strobe_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic pulse_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= strobe_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s3 is only an edge-detect delay; s2 is the first metastability-safe copy.
  assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Strobe-captured instruction FIFO feeding the compute unit over valid/ready.
// Optional INSTR_NOP_DROP_EN: discard NOP/undefined opcodes at push time.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = IW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   wr_strobe,
  input  logic [IW-1:0]          in_instr,
  instr_fetch_queue_if.master    out_if,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] mem_q [DEPTH];
  logic          overflow_q, overflow_d;
  logic          push_req, keep, full, empty, out_valid, pop, push;

  instr_fetch_queue_strobe_sync_edge u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .strobe_i (wr_strobe),
    .pulse_o  (push_req)
  );

`ifdef INSTR_NOP_DROP_EN
  assign keep = ~instr_is_droppable(`IFQ_OP(in_instr));
`else
  assign keep = 1'b1;
`endif

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid = ena & ~empty;
  assign pop       = out_valid & out_if.out_ready;
  assign push      = ena & push_req & keep & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (ena && push_req && keep && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_instr;
    end
  end

  assign out_if.out_valid = out_valid;
  assign out_if.out_instr = mem_q[rd_ptr_q[AW-1:0]];
  assign count            = wr_ptr_q - rd_ptr_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed plus randomized bench for instr_fetch_queue against a queue-based model.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int IW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          wr_strobe = 1'b0;
  logic [IW-1:0] in_instr = '0;
  logic [CW-1:0] count;
  logic          overflow;

  instr_fetch_queue_if #(.IW(IW)) q_if ();

  instr_fetch_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wr_strobe (wr_strobe),
    .in_instr  (in_instr),
    .out_if    (q_if),
    .count     (count),
    .overflow  (overflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [IW-1:0] exp_q[$];
  logic          exp_ovf = 1'b0;
  logic          exp_ena = 1'b0;
  int            n_pass = 0;
  int            n_fail = 0;
  int            n_total = 0;

  function automatic bit model_keeps(input logic [IW-1:0] ins);
    bit drop_en = 1'b0;
`ifdef INSTR_NOP_DROP_EN
    drop_en = 1'b1;
`endif
    return !(drop_en && ((ins[15:12] == 4'h0) || ins[15]));
  endfunction

  // A push edge, optionally coinciding with a pop edge.
  task automatic model_edge(input logic [IW-1:0] ins, input bit do_push, input bit ready);
    bit popped;
    popped = exp_ena && ready && (exp_q.size() > 0);
    if (popped) void'(exp_q.pop_front());
    if (do_push && exp_ena && model_keeps(ins)) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(ins);
      else exp_ovf = 1'b1;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_valid"}, 32'(q_if.out_valid), 32'(exp_ena && exp_q.size() > 0));
    if (exp_ena && exp_q.size() > 0) chk({tag, "_instr"}, 32'(q_if.out_instr), 32'(exp_q[0]));
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe rise lands just after an edge; the push happens on the third edge.
  task automatic push_op(input logic [IW-1:0] ins);
    in_instr  = ins;
    wr_strobe = 1'b1;
    step();
    step();
    step();
    model_edge(ins, 1'b1, 1'b0);
    wr_strobe = 1'b0;
    step();
  endtask

  task automatic pop_op();
    q_if.out_ready = 1'b1;
    step();
    model_edge('0, 1'b0, 1'b1);
    q_if.out_ready = 1'b0;
  endtask

  task automatic pushpop_op(input logic [IW-1:0] ins);
    in_instr  = ins;
    wr_strobe = 1'b1;
    step();
    step();
    q_if.out_ready = 1'b1;
    step();
    model_edge(ins, 1'b1, 1'b1);
    q_if.out_ready = 1'b0;
    wr_strobe      = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    q_if.out_ready = 1'b0;
    step();

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_valid", 32'(q_if.out_valid), 32'd0);
    chk("rst_instr", 32'(q_if.out_instr), 32'd0);
    rst_n = 1'b1;
    ena = 1'b1;
    exp_ena = 1'b1;
    step();

    // Single instruction: latency and immediate consumption
    q_if.out_ready = 1'b1;
    in_instr  = 16'h1A05;
    wr_strobe = 1'b1;
    step();
    step();
    chk("t1_not_yet", 32'(q_if.out_valid), 32'd0);
    step();
    chk("t1_valid", 32'(q_if.out_valid), 32'd1);
    chk("t1_instr", 32'(q_if.out_instr), 32'h1A05);
    chk("t1_count", 32'(count), 32'd1);
    step();
    chk("t1_drained", 32'(count), 32'd0);
    chk("t1_valid_lo", 32'(q_if.out_valid), 32'd0);
    q_if.out_ready = 1'b0;
    wr_strobe = 1'b0;
    step();

    // Full FIFO with a push coinciding with a pop
    for (int i = 1; i <= DEPTH; i++) push_op(16'h1200 + 16'(i));
    check_state("t3_full");
    pushpop_op(16'h1205);
    check_state("t3_pushpop");
    chk("t3_count4", 32'(count), 32'd4);
    for (int i = 0; i < DEPTH; i++) begin
      check_state("t3_drain");
      pop_op();
    end
    check_state("t3_empty");

    // Overflow on the fifth instruction, then in-order drain
    for (int i = 1; i <= 5; i++) push_op(16'h1100 + 16'(i));
    check_state("t2_full");
    chk("t2_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("t2_order", 32'(q_if.out_instr), 32'h1100 + 32'(i));
      pop_op();
    end
    check_state("t2_empty");

    // Disabled stage discards strobes and holds the queue
    push_op(16'h3456);
    push_op(16'h3457);
    ena = 1'b0;
    exp_ena = 1'b0;
    step();
    check_state("t4_off");
    push_op(16'h2312);
    pop_op();
    check_state("t4_off_hold");
    ena = 1'b1;
    exp_ena = 1'b1;
    step();
    check_state("t4_on");

    // Asynchronous reset mid-stream
    push_op(16'h3458);
    chk("t5_count3", 32'(count), 32'd3);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check_state("t5_async");
    step();
    rst_n = 1'b1;
    step();
    check_state("t5_after");

    // NOP and undefined opcode handling
    push_op(16'h0000);
    push_op(16'h9123);
    check_state("t6");

    // Randomized operation mix
    do_reset();
    for (int n = 0; n < 80; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel <= 3) push_op(16'($urandom_range(0, 16'hFFFF)));
      else if (sel <= 6) pop_op();
      else if (sel <= 8) pushpop_op(16'($urandom_range(0, 16'hFFFF)));
      else begin
        ena = ($urandom_range(0, 3) != 0);
        exp_ena = ena;
        step();
      end
      check_state("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
